// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training, clear and statistics update on the rising clock edge.
module bp_btb #(
    parameter int          XLEN     = 32,
    parameter int          ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_next_pc,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic              clear,
    output logic [31:0]       upd_count,
    output logic [31:0]       mispred_count
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    logic              valid_r  [ENTRIES];
    logic [TAGW-1:0]   tag_r    [ENTRIES];
    logic [XLEN-1:0]   target_r [ENTRIES];
    logic [1:0]        ctr_r    [ENTRIES];
    logic              jump_r   [ENTRIES];

    logic [31:0]       upd_count_r;
    logic [31:0]       mispred_count_r;

    logic [IDXW-1:0]   lk_idx_s;
    logic [TAGW-1:0]   lk_tag_s;
    logic [IDXW-1:0]   up_idx_s;
    logic [TAGW-1:0]   up_tag_s;
    logic              up_hit_s;
    logic              up_taken_s;
    logic              upd_pc_unused_s;

    logic              wr_en_s;
    logic [XLEN-1:0]   wr_target_s;
    logic [1:0]        wr_ctr_s;
    logic              wr_jump_s;

    assign lk_idx_s        = lookup_pc[IDXW+1:2];
    assign lk_tag_s        = lookup_pc[XLEN-1:IDXW+2];
    assign up_idx_s        = upd_pc[IDXW+1:2];
    assign up_tag_s        = upd_pc[XLEN-1:IDXW+2];
    assign upd_pc_unused_s = ^upd_pc[1:0];
    assign up_hit_s        = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    assign up_taken_s      = upd_is_jump | upd_taken;

    // Fetch-side prediction straight from the table, no bypass of a same-cycle update.
    always_comb begin
        pred_hit     = 1'b0;
        pred_taken   = 1'b0;
        pred_next_pc = lookup_pc + XLEN'(3'd4);
        if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
            pred_hit = 1'b1;
            if (jump_r[lk_idx_s] || ctr_r[lk_idx_s][1]) begin
                pred_taken   = 1'b1;
                pred_next_pc = target_r[lk_idx_s];
            end else begin
                pred_taken   = 1'b0;
            end
        end else begin
            pred_hit = 1'b0;
        end
    end

    // New contents for the indexed entry; a not-taken miss leaves the table untouched.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_target_s = target_r[up_idx_s];
        wr_ctr_s    = ctr_r[up_idx_s];
        wr_jump_s   = jump_r[up_idx_s];
        if (upd_valid && !clear) begin
            if (up_hit_s) begin
                wr_en_s = 1'b1;
                if (upd_is_jump) begin
                    wr_ctr_s    = 2'b11;
                    wr_jump_s   = 1'b1;
                    wr_target_s = upd_target;
                end else begin
                    wr_ctr_s  = ctr_step(ctr_r[up_idx_s], upd_taken);
                    wr_jump_s = 1'b0;
                    if (upd_taken) begin
                        wr_target_s = upd_target;
                    end else begin
                        wr_target_s = target_r[up_idx_s];
                    end
                end
            end else if (up_taken_s) begin
                wr_en_s     = 1'b1;
                wr_target_s = upd_target;
                wr_jump_s   = upd_is_jump;
                wr_ctr_s    = upd_is_jump ? 2'b11 : 2'b10;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage: clear only drops valid bits and wins over training.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= CTR_INIT;
                jump_r[i]   <= 1'b0;
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= wr_target_s;
            ctr_r[up_idx_s]    <= wr_ctr_s;
            jump_r[up_idx_s]   <= wr_jump_s;
        end
    end

    // Free-running statistics, unaffected by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_count_r     <= 32'd0;
            mispred_count_r <= 32'd0;
        end else if (upd_valid) begin
            upd_count_r <= upd_count_r + 32'd1;
            if (upd_mispredict) begin
                mispred_count_r <= mispred_count_r + 32'd1;
            end
        end
    end

    assign upd_count     = upd_count_r;
    assign mispred_count = mispred_count_r;

endmodule

// File: tb/tb_bp_btb.sv
// Bench for bp_btb: directed vector table, mid-cycle reset, counter wrap, then random
// traffic compared against an array-based model of the predictor rules.
module tb_bp_btb;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDXW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_next_pc;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_mispredict;
    logic              clear;
    logic [31:0]       upd_count;
    logic [31:0]       mispred_count;

    always #5 clk = ~clk;

    bp_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_INIT(2'b01)) dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clear(clear), .upd_count(upd_count), .mispred_count(mispred_count)
    );

    typedef struct {
        logic [31:0] lk;
        bit          uv;
        logic [31:0] upc;
        bit          ujump;
        bit          utaken;
        logic [31:0] utgt;
        bit          umis;
        bit          clr;
        bit          eh;
        bit          et;
        logic [31:0] en;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    logic [31:0] m_upd;
    logic [31:0] m_mis;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0;
            m_ctr[i] = 1; m_jump[i] = 1'b0;
        end
        m_upd = 32'd0;
        m_mis = 32'd0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit hit,
                                          output bit taken, output logic [31:0] nxt);
        int idx = int'((pc >> 2) % ENTRIES);
        hit   = m_valid[idx] && (m_tag[idx] == (pc >> (IDXW + 2)));
        taken = hit && (m_jump[idx] || m_ctr[idx] >= 2);
        nxt   = taken ? m_target[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input vec_t v);
        int idx = int'((v.upc >> 2) % ENTRIES);
        bit tk  = v.ujump || v.utaken;
        bit hit = m_valid[idx] && (m_tag[idx] == (v.upc >> (IDXW + 2)));
        if (v.uv) begin
            m_upd = m_upd + 32'd1;
            if (v.umis) m_mis = m_mis + 32'd1;
        end
        if (v.clr) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (v.uv && hit) begin
            if (v.ujump) begin
                m_ctr[idx] = 3; m_jump[idx] = 1'b1; m_target[idx] = v.utgt;
            end else begin
                m_jump[idx] = 1'b0;
                if (v.utaken) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_target[idx] = v.utgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end
        end else if (v.uv && tk) begin
            m_valid[idx] = 1'b1; m_tag[idx] = v.upc >> (IDXW + 2); m_target[idx] = v.utgt;
            m_jump[idx] = v.ujump; m_ctr[idx] = v.ujump ? 3 : 2;
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                                input bit ujump, input bit utaken, input logic [31:0] utgt,
                                input bit umis, input bit clr, input bit eh, input bit et,
                                input logic [31:0] en);
        vec_t v;
        v.lk = lk; v.uv = uv; v.upc = upc; v.ujump = ujump; v.utaken = utaken;
        v.utgt = utgt; v.umis = umis; v.clr = clr; v.eh = eh; v.et = et; v.en = en;
        return v;
    endfunction

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    // One clock: drive, sample at the falling edge, then advance the model past the rising edge.
    task automatic run_cycle(input vec_t v, input bit use_table);
        bit          mh;
        bit          mt;
        logic [31:0] mn;
        lookup_pc = v.lk; upd_valid = v.uv; upd_pc = v.upc; upd_is_jump = v.ujump;
        upd_taken = v.utaken; upd_target = v.utgt; upd_mispredict = v.umis; clear = v.clr;
        @(negedge clk);
        model_predict(v.lk, mh, mt, mn);
        if (use_table) begin
            mh = v.eh; mt = v.et; mn = v.en;
        end
        check("pred_hit", {31'd0, pred_hit}, {31'd0, mh});
        check("pred_taken", {31'd0, pred_taken}, {31'd0, mt});
        check("pred_next_pc", pred_next_pc, mn);
        check("upd_count", upd_count, m_upd);
        check("mispred_count", mispred_count, m_mis);
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    vec_t tbl[17];
    vec_t rv;

    initial begin
        // lookup, uv, upc, jump, taken, target, mispred, clear | exp hit, taken, next
        tbl[0]  = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h104);
        tbl[1]  = mk(32'h100, 1, 32'h100, 0, 1, 32'h200, 0, 0, 0, 0, 32'h104);
        tbl[2]  = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h200);
        tbl[3]  = mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 0, 1, 1, 32'h200);
        tbl[4]  = mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 1, 0, 32'h104);
        tbl[5]  = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 0, 32'h104);
        tbl[6]  = mk(32'h100, 1, 32'h140, 0, 1, 32'h500, 1, 0, 1, 0, 32'h104);
        tbl[7]  = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h104);
        tbl[8]  = mk(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h500);
        tbl[9]  = mk(32'h80,  1, 32'h80,  1, 0, 32'h300, 0, 0, 0, 0, 32'h84);
        tbl[10] = mk(32'h80,  0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 32'h300);
        tbl[11] = mk(32'h200, 1, 32'h200, 0, 0, 32'h44,  0, 0, 0, 0, 32'h204);
        tbl[12] = mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h204);
        tbl[13] = mk(32'h80,  1, 32'h300, 0, 1, 32'h10,  0, 1, 1, 1, 32'h300);
        tbl[14] = mk(32'h80,  0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h84);
        tbl[15] = mk(32'h300, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h304);
        tbl[16] = mk(32'hFFFFFFFC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);

        reset = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_pc = 32'd0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = 32'd0; upd_mispredict = 1'b0; lookup_pc = 32'h100;
        model_reset();
        #2;
        check("reset_hit", {31'd0, pred_hit}, 32'd0);
        check("reset_next_pc", pred_next_pc, 32'h104);
        check("reset_upd_count", upd_count, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 17; i++) run_cycle(tbl[i], 1'b1);

        // Asynchronous reset in the middle of an update cycle.
        run_cycle(mk(32'h100, 1, 32'h100, 1, 1, 32'h700, 1, 0, 0, 0, 32'h0), 1'b0);
        lookup_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1;
        upd_is_jump = 1'b0; upd_target = 32'h900; upd_mispredict = 1'b1; clear = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_upd_count", upd_count, 32'd0);
        check("async_mispred_count", mispred_count, 32'd0);
        check("async_hit", {31'd0, pred_hit}, 32'd0);
        check("async_next_pc", pred_next_pc, 32'h104);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        run_cycle(mk(32'h104, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0), 1'b0);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.upd_count_r = 32'hFFFFFFFF;
        #1 release dut.upd_count_r;
        m_upd = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        run_cycle(mk(32'h0, 1, 32'h40, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0), 1'b0);
        run_cycle(mk(32'h40, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0), 1'b0);
        check("wrap_upd_count", upd_count, 32'd0);
        check("wrap_mispred_count", mispred_count, 32'd1);

        for (int i = 0; i < 600; i++) begin
            rv = mk(rpc(), 1'($urandom_range(0, 2) != 0), rpc(), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 49) == 0), 0, 0, 32'h0);
            if (($urandom_range(0, 3)) == 0) rv.lk = rv.upc;
            run_cycle(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_btb.md
BP_BTB -- requirements
Module: bp_btb

Interface
REQ-001 Parameter XLEN, default 32, address/data width in bits.
REQ-002 Parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of two, >=2); IDXW = log2(ENTRIES).
REQ-003 Parameter CTR_INIT, default 2'b01, 2-bit counter value loaded at reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 lookup_pc  in  XLEN  PC of the instruction being fetched (IF stage).
REQ-007 pred_hit  out  1  lookup_pc hits a valid entry with matching tag.
REQ-008 pred_taken  out  1  predicted taken for lookup_pc.
REQ-009 pred_next_pc  out  XLEN  predicted next fetch address.
REQ-010 upd_valid  in  1  resolved control-transfer instruction present (ID stage).
REQ-011 upd_pc  in  XLEN  PC of the resolved instruction.
REQ-012 upd_is_jump  in  1  resolved instruction is JAL/JALR (unconditional).
REQ-013 upd_taken  in  1  actual outcome; ignored (treated as 1) when upd_is_jump=1.
REQ-014 upd_target  in  XLEN  actual target address.
REQ-015 upd_mispredict  in  1  pipeline flushed for this instruction (wrong direction or target).
REQ-016 clear  in  1  synchronous invalidate of all entries.
REQ-017 upd_count  out  32  number of accepted updates.
REQ-018 mispred_count  out  32  number of accepted updates with upd_mispredict=1.

Function
REQ-019 Index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
REQ-020 Entry state: valid (1), tag, target (XLEN), ctr (2), jump (1).
REQ-021 Lookup is combinational, zero latency: pred_hit = valid & tag match at index(lookup_pc).
REQ-022 pred_taken = pred_hit & (jump | ctr[1]).
REQ-023 pred_next_pc = pred_taken ? stored target : lookup_pc + 4 (modulo 2^XLEN).
REQ-024 Updates take effect at the rising edge where upd_valid=1; visible to lookups from the next cycle.
REQ-025 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
REQ-026 Update hit, conditional: ctr saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00); target <= upd_target only if taken; jump <= 0.
REQ-027 Update hit, jump: ctr <= 2'b11, jump <= 1, target <= upd_target.
REQ-028 Update miss (invalid or tag mismatch), taken or jump: allocate/replace entry: valid <= 1, tag, target <= upd_target, jump <= upd_is_jump, ctr <= jump ? 2'b11 : 2'b10.
REQ-029 Update miss, not taken, not jump: no entry state changes.
REQ-030 Counter state encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-031 clear=1 at an edge: all valid <= 0; clear has priority over a same-cycle update (update discarded from table, still counted by REQ-032).
REQ-032 upd_count increments by 1 per edge with upd_valid=1; mispred_count increments when upd_valid=1 and upd_mispredict=1; both wrap 2^32-1 -> 0; clear does not affect them.

Reset
REQ-033 reset asserted: immediately all valid=0, ctr=CTR_INIT, target=0, jump=0, upd_count=0, mispred_count=0, independent of clk.
REQ-034 During/after reset, with no updates: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
REQ-035 reset asserted mid-update cycle: update is lost; state equals REQ-033 after reset deasserts.

Verification
REQ-036 After reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104.
REQ-037 Update pc=0x100 taken target=0x200 (branch); next cycle lookup 0x100 -> hit=1, taken=1, next_pc=0x200; two not-taken updates -> ctr 00, taken=0, next_pc=0x104.
REQ-038 ENTRIES=16: allocate 0x100 then taken update 0x140 (same index, new tag) -> lookup 0x100 hit=0, lookup 0x140 hit=1 target from second update.
REQ-039 JAL update pc=0x80 target=0x300, then 3 not-taken-style conditional updates are not issued; lookup 0x80 -> taken=1 always; same-cycle update and lookup of 0x80 first time -> hit=0 that cycle, hit=1 next.
REQ-040 clear and taken update same cycle -> all lookups miss next cycle, upd_count +1.
REQ-041 Counter wrap: preload 0xFFFFFFFF updates (or force), one more upd_valid with upd_mispredict=1 -> upd_count=0, mispred_count incremented; async reset mid-cycle -> counters 0 before next edge.
